decim_ctrl: RTL

Sequencer for the PDM decimation chain (CIC ÷16 → halfband ÷4 → halfband ÷3 → droop-correcting FIR) running on the 2.304 MHz mic clock domain. It generates per-stage single-cycle clock-enable strobes at the correct decimated rates and suppresses filter start-up transients with a settle phase. It also registers the FIR output into the final `audio_sample`/`audio_valid` stream. It replaces free-running stage logic so the whole chain starts, stops and restarts coherently from one enable.

---
 rtl/decim_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/decim_ctrl.sv
// Decimation-chain sequencer: per-stage clock-enable strobes, settle phase and output sample register.
// Optional DECIM_CTRL_SAMPLE_CNT_EN builds a 32-bit count of delivered samples.
module decim_ctrl #(
  parameter int CIC_DECIM      = 16,
  parameter int HB1_DECIM      = 4,
  parameter int HB2_DECIM      = 3,
  parameter int SETTLE_SAMPLES = 64,
  parameter int FIR_LAT        = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] fir_data,
  output logic        cic_ce,
  output logic        hb2_ce,
  output logic        fir_ce,
  output logic [1:0]  state,
  output logic [15:0] audio_sample,
  output logic        audio_valid,
  output logic [31:0] sample_count
);

  localparam int CIC_W = (CIC_DECIM > 1) ? $clog2(CIC_DECIM) : 1;
  localparam int HB1_W = (HB1_DECIM > 1) ? $clog2(HB1_DECIM) : 1;
  localparam int HB2_W = (HB2_DECIM > 1) ? $clog2(HB2_DECIM) : 1;
  localparam int SET_W = $clog2(SETTLE_SAMPLES + 1);

  localparam logic [CIC_W-1:0] CIC_LAST = CIC_W'(CIC_DECIM - 1);
  localparam logic [CIC_W-1:0] CIC_ONE  = CIC_W'(1);
  localparam logic [HB1_W-1:0] HB1_LAST = HB1_W'(HB1_DECIM - 1);
  localparam logic [HB1_W-1:0] HB1_ONE  = HB1_W'(1);
  localparam logic [HB2_W-1:0] HB2_LAST = HB2_W'(HB2_DECIM - 1);
  localparam logic [HB2_W-1:0] HB2_ONE  = HB2_W'(1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_SAMPLES - 1);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETTLE = 2'b01;
  localparam logic [1:0] ST_RUN    = 2'b10;

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [CIC_W-1:0]   cic_cnt_r;
  logic [HB1_W-1:0]   hb1_ph_r;
  logic [HB2_W-1:0]   hb2_ph_r;
  logic [SET_W-1:0]   settle_cnt_r;
  logic [FIR_LAT-1:0] dly_r;
  logic [FIR_LAT-1:0] dly_nxt_s;
  logic [15:0]        audio_sample_r;
  logic               active_s;
  logic               run_s;
  logic               settling_s;
  logic               cic_ce_s;
  logic               hb2_ce_s;
  logic               fir_ce_s;
  logic               settle_done_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; dropping enable returns to IDLE from anywhere
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   state_nxt_s = enable ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: begin
        if (!enable) begin
          state_nxt_s = ST_IDLE;
        end else if (settle_done_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_RUN:    state_nxt_s = enable ? ST_RUN : ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State-dependent qualifiers
  always_comb begin
    active_s   = 1'b0;
    run_s      = 1'b0;
    settling_s = 1'b0;
    case (state_r)
      ST_SETTLE: begin
        active_s   = 1'b1;
        settling_s = 1'b1;
      end
      ST_RUN: begin
        active_s = 1'b1;
        run_s    = 1'b1;
      end
      default: begin
        active_s   = 1'b0;
        run_s      = 1'b0;
        settling_s = 1'b0;
      end
    endcase
  end

  // Strobes decode directly from the registered phase counters
  always_comb begin
    cic_ce_s      = active_s && (cic_cnt_r == CIC_LAST);
    hb2_ce_s      = cic_ce_s && (hb1_ph_r == HB1_LAST);
    fir_ce_s      = hb2_ce_s && (hb2_ph_r == HB2_LAST);
    settle_done_s = settling_s && fir_ce_s && (settle_cnt_r == SET_LAST);
  end

  // Phase and settle counters; cleared whenever the chain is about to go idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cic_cnt_r    <= {CIC_W{1'b0}};
      hb1_ph_r     <= {HB1_W{1'b0}};
      hb2_ph_r     <= {HB2_W{1'b0}};
      settle_cnt_r <= {SET_W{1'b0}};
    end else if (!enable) begin
      cic_cnt_r    <= {CIC_W{1'b0}};
      hb1_ph_r     <= {HB1_W{1'b0}};
      hb2_ph_r     <= {HB2_W{1'b0}};
      settle_cnt_r <= {SET_W{1'b0}};
    end else if (active_s) begin
      cic_cnt_r <= cic_ce_s ? {CIC_W{1'b0}} : (cic_cnt_r + CIC_ONE);
      if (cic_ce_s) begin
        hb1_ph_r <= (hb1_ph_r == HB1_LAST) ? {HB1_W{1'b0}} : (hb1_ph_r + HB1_ONE);
      end else begin
        hb1_ph_r <= hb1_ph_r;
      end
      if (hb2_ce_s) begin
        hb2_ph_r <= (hb2_ph_r == HB2_LAST) ? {HB2_W{1'b0}} : (hb2_ph_r + HB2_ONE);
      end else begin
        hb2_ph_r <= hb2_ph_r;
      end
      if (settling_s && fir_ce_s && !settle_done_s) begin
        settle_cnt_r <= settle_cnt_r + SET_ONE;
      end else begin
        settle_cnt_r <= settle_cnt_r;
      end
    end else begin
      cic_cnt_r    <= cic_cnt_r;
      hb1_ph_r     <= hb1_ph_r;
      hb2_ph_r     <= hb2_ph_r;
      settle_cnt_r <= settle_cnt_r;
    end
  end

  // Valid delay line input: only RUN-phase FIR strobes produce output samples
  always_comb begin
    dly_nxt_s    = {FIR_LAT{1'b0}};
    dly_nxt_s[0] = run_s && fir_ce_s;
    for (int i = 1; i < FIR_LAT; i++) begin
      dly_nxt_s[i] = dly_r[i-1];
    end
  end

  // Delay line and output sample; the sample loads on the edge that raises audio_valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dly_r          <= {FIR_LAT{1'b0}};
      audio_sample_r <= 16'h0000;
    end else if (!enable) begin
      dly_r          <= {FIR_LAT{1'b0}};
      audio_sample_r <= audio_sample_r;
    end else begin
      dly_r          <= dly_nxt_s;
      audio_sample_r <= dly_nxt_s[FIR_LAT-1] ? fir_data : audio_sample_r;
    end
  end

`ifdef DECIM_CTRL_SAMPLE_CNT_EN
  logic [31:0] sample_cnt_r;

  // Delivered-sample counter, cleared only by reset and wrapping naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_cnt_r <= 32'd0;
    end else if (dly_r[FIR_LAT-1]) begin
      sample_cnt_r <= sample_cnt_r + 32'd1;
    end else begin
      sample_cnt_r <= sample_cnt_r;
    end
  end

  assign sample_count = sample_cnt_r;
`else
  assign sample_count = 32'd0;
`endif

  assign cic_ce       = cic_ce_s;
  assign hb2_ce       = hb2_ce_s;
  assign fir_ce       = fir_ce_s;
  assign state        = state_r;
  assign audio_sample = audio_sample_r;
  assign audio_valid  = dly_r[FIR_LAT-1];

endmodule
